pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register in each core.
- Each cycle it computes the latch enable/flush/freeze controls from cache hit status, load-use hazards, branch/jump redirects and halt.
- It tracks outstanding data-memory accesses, remembers early instruction hits, latches the halt condition and keeps stall/flush performance counters.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: sequencer states and the per-latch control bundle.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hazctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
    logic freeze;
  } latch_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in ID/EX whose destination feeds an IF/ID source.
// Purely combinational; r0 is never a hazard because it is hardwired to zero.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             lu_hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (ex_rd == id_rs1);
  assign rs2_match = id_use_rs2 && (ex_rd == id_rs2);
  assign lu_hazard = ex_dREN && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch sequencer: enables/flushes/freezes from cache hits, hazards, redirects, halt.
// Controls are combinational (0-cycle); only state, ihit_seen and the saturating counters are flopped.
module pipe_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             idex_freeze,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazctrl_state_t state, state_nxt;
  logic           ihit_seen, ihit_seen_nxt;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic           stall_inc, flush_inc;
  logic           dreq, ihit_ok, dmem_ok, adv;
  logic           lu_hazard;
  latch_ctrl_t    idex_c;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .ex_dREN    (ex_dREN),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .lu_hazard  (lu_hazard)
  );

  assign dreq    = mem_dREN || mem_dWEN;
  assign ihit_ok = ihit || ihit_seen;
  assign dmem_ok = !dreq || dhit;
  assign adv     = ihit_ok && dmem_ok;

  always_comb begin
    state_nxt     = state;
    ihit_seen_nxt = ihit_seen;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b0;
    idex_c        = '0;
    exmem_en      = 1'b0;
    exmem_flush   = 1'b0;
    memwb_en      = 1'b0;
    halted        = 1'b0;

    // Reset forces every control low in the same cycle.
    if (!RST) begin
      if (state == HALTED) begin
        halted = 1'b1;
      end else if (wb_halt) begin
        // Squash EX/MEM so anything younger than the halt never commits.
        exmem_en      = 1'b1;
        exmem_flush   = 1'b1;
        state_nxt     = HALTED;
        ihit_seen_nxt = 1'b0;
      end else begin
        if (state == RUN && dreq && !dhit)
          state_nxt = DWAIT;
        else if (state == DWAIT && dhit)
          state_nxt = RUN;

        if (!adv) begin
          stall_inc = 1'b1;
          if (ihit)
            ihit_seen_nxt = 1'b1;
        end else begin
          ihit_seen_nxt = 1'b0;
          pc_en         = 1'b1;
          ifid_en       = 1'b1;
          idex_c.en     = 1'b1;
          exmem_en      = 1'b1;
          memwb_en      = 1'b1;
          if (ex_redirect) begin
            ifid_flush   = 1'b1;
            idex_c.flush = 1'b1;
            flush_inc    = 1'b1;
          end else if (lu_hazard) begin
            // Hold fetch/decode and push a bubble into EX.
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            idex_c.freeze = 1'b1;
            stall_inc     = 1'b1;
          end
        end
      end
    end
  end

  assign idex_en     = idex_c.en;
  assign idex_flush  = idex_c.flush;
  assign idex_freeze = idex_c.freeze;
  assign stall_cnt   = RST ? '0 : stall_q;
  assign flush_cnt   = RST ? '0 : flush_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      ihit_seen <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state     <= state_nxt;
      ihit_seen <= ihit_seen_nxt;
      if (stall_inc && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: driver applies stimulus and queues the model's expected controls,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int REG_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             rst;
    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             ex_dREN;
    logic [REG_W-1:0] ex_rd;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             use1;
    logic             use2;
    logic             redirect;
    logic             wb_halt;
  } stim_t;

  typedef struct packed {
    logic [9:0]         ctl;
    logic [2*CNT_W-1:0] cnt;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ihit = 1'b0, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0, ex_dREN = 1'b0;
  logic [REG_W-1:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_redirect = 1'b0, wb_halt = 1'b0;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze;
  logic             exmem_en, exmem_flush, memwb_en, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  // Reference model state: only what is visible from outside matters.
  logic           m_halted = 1'b0;
  logic           m_seen   = 1'b0;
  int             m_stall  = 0;
  int             m_flush  = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_redirect(ex_redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .idex_freeze(idex_freeze),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ihit = 1'b1;
    return s;
  endfunction

  task automatic cyc(input stim_t s);
    exp_t e;
    logic pe, ie, ifl, de, dfl, dfz, xe, xfl, we, h;
    logic adv, lu;
    @(posedge CLK);
    #1;
    RST = s.rst; ihit = s.ihit; dhit = s.dhit; mem_dREN = s.mem_dREN; mem_dWEN = s.mem_dWEN;
    ex_dREN = s.ex_dREN; ex_rd = s.ex_rd; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2; ex_redirect = s.redirect; wb_halt = s.wb_halt;

    {pe, ie, ifl, de, dfl, dfz, xe, xfl, we, h} = '0;
    e.cnt = {CNT_W'(m_stall), CNT_W'(m_flush)};
    if (s.rst) begin
      e.cnt = '0;
      m_halted = 1'b0; m_seen = 1'b0; m_stall = 0; m_flush = 0;
    end else if (m_halted) begin
      h = 1'b1;
    end else if (s.wb_halt) begin
      xe = 1'b1; xfl = 1'b1;
      m_halted = 1'b1;
    end else begin
      adv = (s.ihit || m_seen) && (!(s.mem_dREN || s.mem_dWEN) || s.dhit);
      lu  = s.ex_dREN && (s.ex_rd != 0) &&
            ((s.ex_rd == s.id_rs1 && s.use1) || (s.ex_rd == s.id_rs2 && s.use2));
      if (!adv) begin
        if (s.ihit) m_seen = 1'b1;
        if (m_stall < CMAX) m_stall++;
      end else begin
        m_seen = 1'b0;
        if (s.redirect) begin
          {pe, ie, de, xe, we} = '1;
          ifl = 1'b1; dfl = 1'b1;
          if (m_flush < CMAX) m_flush++;
        end else if (lu) begin
          de = 1'b1; dfz = 1'b1; xe = 1'b1; we = 1'b1;
          if (m_stall < CMAX) m_stall++;
        end else begin
          {pe, ie, de, xe, we} = '1;
        end
      end
    end
    e.ctl = {pe, ie, ifl, de, dfl, dfz, xe, xfl, we, h};
    sb_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    logic [9:0] act_ctl;
    logic [2*CNT_W-1:0] act_cnt;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act_ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze,
                 exmem_en, exmem_flush, memwb_en, halted};
      act_cnt = {stall_cnt, flush_cnt};
      total++;
      if (act_ctl !== e.ctl) begin
        bad++;
        $display("FAIL ctl t=%0t got=%b want=%b (pc ifid ifidF idex idexF idexZ exmem exmemF memwb halted)",
                 $time, act_ctl, e.ctl);
      end
      total++;
      if (act_cnt !== e.cnt) begin
        bad++;
        $display("FAIL cnt t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 $time, stall_cnt, flush_cnt, e.cnt[2*CNT_W-1:CNT_W], e.cnt[CNT_W-1:0]);
      end
    end
  end

  function automatic logic pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  initial begin
    stim_t s;
    // Reset with arbitrary side inputs.
    for (int i = 0; i < 2; i++) begin
      s = stim_t'({$urandom, $urandom});
      s.rst = 1'b1;
      cyc(s);
    end
    cyc(idle());
    // Instruction miss for three cycles.
    s = idle(); s.ihit = 1'b0;
    repeat (3) cyc(s);
    repeat (2) cyc(idle());
    // Data wait with an early instruction hit.
    s = idle(); s.mem_dREN = 1'b1;
    cyc(s);
    s.ihit = 1'b0;
    repeat (3) cyc(s);
    s.dhit = 1'b1;
    cyc(s);
    cyc(idle());
    // Load-use on rs2, then the same with rd=0.
    s = idle(); s.ex_dREN = 1'b1; s.ex_rd = 5'd5; s.id_rs2 = 5'd5; s.use2 = 1'b1;
    cyc(s);
    s.ex_rd = 5'd0; s.id_rs2 = 5'd0;
    cyc(s);
    // Redirect beats load-use.
    s.ex_rd = 5'd5; s.id_rs2 = 5'd5; s.redirect = 1'b1;
    cyc(s);
    // Redirect held behind a data miss.
    s = idle(); s.redirect = 1'b1; s.mem_dWEN = 1'b1;
    repeat (2) cyc(s);
    s.dhit = 1'b1;
    cyc(s);
    // Saturation: 20 stalls.
    s = idle(); s.ihit = 1'b0;
    repeat (20) cyc(s);
    cyc(idle());
    // Halt, stay halted, then reset out.
    s = idle(); s.wb_halt = 1'b1;
    cyc(s);
    for (int i = 0; i < 4; i++) begin
      s = stim_t'({$urandom, $urandom});
      s.rst = 1'b0;
      cyc(s);
    end
    s = idle(); s.rst = 1'b1;
    cyc(s);
    repeat (2) cyc(idle());
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      s = '0;
      s.rst      = pct(3);
      s.ihit     = pct(75);
      s.dhit     = pct(50);
      s.mem_dREN = pct(20);
      s.mem_dWEN = pct(15);
      s.ex_dREN  = pct(50);
      s.ex_rd    = REG_W'($urandom_range(3, 0));
      s.id_rs1   = REG_W'($urandom_range(3, 0));
      s.id_rs2   = REG_W'($urandom_range(3, 0));
      s.use1     = pct(60);
      s.use2     = pct(60);
      s.redirect = pct(15);
      s.wb_halt  = pct(2);
      cyc(s);
    end
    repeat (3) @(posedge CLK);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
